// File: rtl/bus_grant_arbiter4.sv
// Four-requester round-robin arbiter driving a 4:1 bus mux select/enable, with a dead cycle between owners.
// Optional forced hand-off after MAX_TENURE grant cycles when compiled with ARB_TIMEOUT_EN.
module bus_grant_arbiter4 #(
  parameter int MAX_TENURE = 16,
  parameter int CNT_W      = 5
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] select,
  output logic       enable,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, HANDOFF} state_t;

  state_t     state_reg, state_next;
  logic [3:0] grant_reg, grant_next;
  logic [1:0] select_reg, select_next;
  logic [1:0] last_owner_reg, last_owner_next;
  logic       enable_reg, enable_next;
  logic       any_req;
  logic       owner_req;
  logic       expire;
  logic [1:0] winner;

  assign any_req   = |req;
  assign owner_req = req[select_reg];

  // Round-robin search starting just past the last owner; the last owner itself is tried last.
  always_comb begin
    winner = last_owner_reg;
    for (int k = 4; k >= 1; k--) begin
      if (req[last_owner_reg + 2'(k)]) winner = last_owner_reg + 2'(k);
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_TENURE - 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             timeout_reg, timeout_next;

  // Expiry only forces rotation when someone else is waiting; otherwise the counter saturates.
  assign expire  = (state_reg == GRANT) && (cnt_reg == CNT_LAST) && |(req & ~grant_reg);
  assign timeout = timeout_reg;

  always_ff @(posedge clock) begin
    if (clear) begin
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (clear) begin
      state_reg      <= IDLE;
      grant_reg      <= 4'b0000;
      select_reg     <= 2'b00;
      enable_reg     <= 1'b0;
      last_owner_reg <= 2'd3;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      select_reg     <= select_next;
      enable_reg     <= enable_next;
      last_owner_reg <= last_owner_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, HANDOFF: state_next = any_req ? GRANT : IDLE;
      GRANT:         state_next = (!owner_req || expire) ? HANDOFF : GRANT;
      default:       state_next = IDLE;
    endcase
  end

  always_comb begin
    grant_next      = grant_reg;
    select_next     = select_reg;
    enable_next     = enable_reg;
    last_owner_next = last_owner_reg;
`ifdef ARB_TIMEOUT_EN
    cnt_next        = cnt_reg;
    timeout_next    = 1'b0;
`endif
    if (state_reg != GRANT && state_next == GRANT) begin
      grant_next      = 4'b0001 << winner;
      select_next     = winner;
      enable_next     = 1'b1;
      last_owner_next = winner;
`ifdef ARB_TIMEOUT_EN
      cnt_next        = '0;
`endif
    end else if (state_next != GRANT) begin
      // select deliberately holds the previous owner while the bus is idle.
      grant_next  = 4'b0000;
      enable_next = 1'b0;
`ifdef ARB_TIMEOUT_EN
      timeout_next = expire;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      cnt_next = (cnt_reg == CNT_LAST) ? cnt_reg : cnt_reg + 1'b1;
`endif
    end
  end

  assign grant  = grant_reg;
  assign select = select_reg;
  assign enable = enable_reg;

endmodule

// File: tb/tb_bus_grant_arbiter4.sv
// Directed-vector bench for bus_grant_arbiter4; each row drives clear/req for one edge and checks
// {grant, select, enable, timeout} one time unit after that edge. Handles both ARB_TIMEOUT_EN builds.
module tb_bus_grant_arbiter4;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic [3:0] req   = 4'b0000;
  logic [3:0] grant;
  logic [1:0] select;
  logic       enable;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  bus_grant_arbiter4 #(.MAX_TENURE(4), .CNT_W(5)) dut (
    .clock   (clock),
    .clear   (clear),
    .req     (req),
    .grant   (grant),
    .select  (select),
    .enable  (enable),
    .timeout (timeout)
  );

  always #5 clock = ~clock;

  // Row layout: {clear, req[3:0], grant[3:0], select[1:0], enable, timeout}
  task automatic test_reset();
    logic [12:0] tbl [5];
    logic [7:0]  obs;
    tbl = '{
      {1'b1, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0},
      {1'b1, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0},
      {1'b0, 4'hF, 4'h1, 2'd0, 1'b1, 1'b0},
      {1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0},
      {1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0}
    };
    foreach (tbl[i]) begin
      clear = tbl[i][12]; req = tbl[i][11:8];
      @(posedge clock); #1;
      obs = {grant, select, enable, timeout};
      n_cmp++;
      if (obs !== tbl[i][7:0]) begin
        n_bad++;
        $display("FAIL reset row %0d: got %b required %b", i, obs, tbl[i][7:0]);
      end else $display("reset row %0d: %b", i, obs);
    end
  endtask

  task automatic test_single();
    logic [12:0] tbl [6];
    logic [7:0]  obs;
    tbl = '{
      {1'b0, 4'h4, 4'h4, 2'd2, 1'b1, 1'b0},
      {1'b0, 4'h4, 4'h4, 2'd2, 1'b1, 1'b0},
      {1'b0, 4'h4, 4'h4, 2'd2, 1'b1, 1'b0},
      {1'b0, 4'h4, 4'h4, 2'd2, 1'b1, 1'b0},
      {1'b0, 4'h0, 4'h0, 2'd2, 1'b0, 1'b0},
      {1'b0, 4'h0, 4'h0, 2'd2, 1'b0, 1'b0}
    };
    foreach (tbl[i]) begin
      clear = tbl[i][12]; req = tbl[i][11:8];
      @(posedge clock); #1;
      obs = {grant, select, enable, timeout};
      n_cmp++;
      if (obs !== tbl[i][7:0]) begin
        n_bad++;
        $display("FAIL single row %0d: got %b required %b", i, obs, tbl[i][7:0]);
      end else $display("single row %0d: %b", i, obs);
    end
  endtask

  task automatic test_rotation();
    logic [12:0] tbl [18];
    logic [7:0]  obs;
    tbl = '{
      {1'b1, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0},
      {1'b0, 4'hF, 4'h1, 2'd0, 1'b1, 1'b0},
      {1'b0, 4'hF, 4'h1, 2'd0, 1'b1, 1'b0},
      {1'b0, 4'hF, 4'h1, 2'd0, 1'b1, 1'b0},
      {1'b0, 4'hE, 4'h0, 2'd0, 1'b0, 1'b0},
      {1'b0, 4'hE, 4'h2, 2'd1, 1'b1, 1'b0},
      {1'b0, 4'hE, 4'h2, 2'd1, 1'b1, 1'b0},
      {1'b0, 4'hE, 4'h2, 2'd1, 1'b1, 1'b0},
      {1'b0, 4'hC, 4'h0, 2'd1, 1'b0, 1'b0},
      {1'b0, 4'hC, 4'h4, 2'd2, 1'b1, 1'b0},
      {1'b0, 4'hC, 4'h4, 2'd2, 1'b1, 1'b0},
      {1'b0, 4'hC, 4'h4, 2'd2, 1'b1, 1'b0},
      {1'b0, 4'h8, 4'h0, 2'd2, 1'b0, 1'b0},
      {1'b0, 4'h8, 4'h8, 2'd3, 1'b1, 1'b0},
      {1'b0, 4'h8, 4'h8, 2'd3, 1'b1, 1'b0},
      {1'b0, 4'h8, 4'h8, 2'd3, 1'b1, 1'b0},
      {1'b0, 4'h0, 4'h0, 2'd3, 1'b0, 1'b0},
      {1'b0, 4'h0, 4'h0, 2'd3, 1'b0, 1'b0}
    };
    foreach (tbl[i]) begin
      clear = tbl[i][12]; req = tbl[i][11:8];
      @(posedge clock); #1;
      obs = {grant, select, enable, timeout};
      n_cmp++;
      if (obs !== tbl[i][7:0]) begin
        n_bad++;
        $display("FAIL rotation row %0d: got %b required %b", i, obs, tbl[i][7:0]);
      end else $display("rotation row %0d: %b", i, obs);
    end
  endtask

  // Owner 1 releases with 0 and 3 pending: 3 must win before 0.
  task automatic test_priority();
    logic [12:0] tbl [8];
    logic [7:0]  obs;
    tbl = '{
      {1'b0, 4'h2, 4'h2, 2'd1, 1'b1, 1'b0},
      {1'b0, 4'hB, 4'h2, 2'd1, 1'b1, 1'b0},
      {1'b0, 4'h9, 4'h0, 2'd1, 1'b0, 1'b0},
      {1'b0, 4'h9, 4'h8, 2'd3, 1'b1, 1'b0},
      {1'b0, 4'h1, 4'h0, 2'd3, 1'b0, 1'b0},
      {1'b0, 4'h1, 4'h1, 2'd0, 1'b1, 1'b0},
      {1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0},
      {1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0}
    };
    foreach (tbl[i]) begin
      clear = tbl[i][12]; req = tbl[i][11:8];
      @(posedge clock); #1;
      obs = {grant, select, enable, timeout};
      n_cmp++;
      if (obs !== tbl[i][7:0]) begin
        n_bad++;
        $display("FAIL priority row %0d: got %b required %b", i, obs, tbl[i][7:0]);
      end else $display("priority row %0d: %b", i, obs);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] obs;
`ifdef ARB_TIMEOUT_EN
    logic [12:0] tbl [10];
    tbl = '{
      {1'b0, 4'h1, 4'h1, 2'd0, 1'b1, 1'b0},
      {1'b0, 4'h3, 4'h1, 2'd0, 1'b1, 1'b0},
      {1'b0, 4'h3, 4'h1, 2'd0, 1'b1, 1'b0},
      {1'b0, 4'h3, 4'h1, 2'd0, 1'b1, 1'b0},
      {1'b0, 4'h3, 4'h0, 2'd0, 1'b0, 1'b1},
      {1'b0, 4'h3, 4'h2, 2'd1, 1'b1, 1'b0},
      {1'b0, 4'h1, 4'h0, 2'd1, 1'b0, 1'b0},
      {1'b0, 4'h1, 4'h1, 2'd0, 1'b1, 1'b0},
      {1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0},
      {1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0}
    };
`else
    logic [12:0] tbl [5];
    tbl = '{
      {1'b0, 4'h1, 4'h1, 2'd0, 1'b1, 1'b0},
      {1'b0, 4'h3, 4'h1, 2'd0, 1'b1, 1'b0},
      {1'b0, 4'h3, 4'h1, 2'd0, 1'b1, 1'b0},
      {1'b0, 4'h3, 4'h1, 2'd0, 1'b1, 1'b0},
      {1'b0, 4'h3, 4'h1, 2'd0, 1'b1, 1'b0}
    };
`endif
    foreach (tbl[i]) begin
      clear = tbl[i][12]; req = tbl[i][11:8];
      @(posedge clock); #1;
      obs = {grant, select, enable, timeout};
      n_cmp++;
      if (obs !== tbl[i][7:0]) begin
        n_bad++;
        $display("FAIL timeout row %0d: got %b required %b", i, obs, tbl[i][7:0]);
      end else $display("timeout row %0d: %b", i, obs);
    end
`ifndef ARB_TIMEOUT_EN
    // Without forced rotation the owner keeps the bus indefinitely.
    for (int c = 0; c < 100; c++) begin
      @(posedge clock); #1;
      obs = {grant, select, enable, timeout};
      n_cmp++;
      if (obs !== 8'b0001_00_1_0) begin
        n_bad++;
        $display("FAIL hold cycle %0d: got %b required 00010010", c, obs);
      end
    end
    $display("hold: 100 cycles observed");
    req = 4'h0;
    @(posedge clock); #1;
    obs = {grant, select, enable, timeout};
    n_cmp++;
    if (obs !== 8'b0000_00_0_0) begin
      n_bad++;
      $display("FAIL hold release: got %b required 00000000", obs);
    end else $display("hold release: %b", obs);
    @(posedge clock); #1;
`endif
  endtask

  task automatic test_mid_reset();
    logic [12:0] tbl [6];
    logic [7:0]  obs;
    tbl = '{
      {1'b0, 4'h8, 4'h8, 2'd3, 1'b1, 1'b0},
      {1'b0, 4'h8, 4'h8, 2'd3, 1'b1, 1'b0},
      {1'b1, 4'h8, 4'h0, 2'd0, 1'b0, 1'b0},
      {1'b0, 4'h8, 4'h8, 2'd3, 1'b1, 1'b0},
      {1'b0, 4'h0, 4'h0, 2'd3, 1'b0, 1'b0},
      {1'b0, 4'h0, 4'h0, 2'd3, 1'b0, 1'b0}
    };
    foreach (tbl[i]) begin
      clear = tbl[i][12]; req = tbl[i][11:8];
      @(posedge clock); #1;
      obs = {grant, select, enable, timeout};
      n_cmp++;
      if (obs !== tbl[i][7:0]) begin
        n_bad++;
        $display("FAIL mid_reset row %0d: got %b required %b", i, obs, tbl[i][7:0]);
      end else $display("mid_reset row %0d: %b", i, obs);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_priority();
    test_timeout();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
